// File: rtl/mc_arb_pkg.sv
// Shared types and constants for the LPDDR2 controller arbiter slice.
// Holds bus widths, the client-ID type, the latched request struct and FSM encodings.
package MCPU_mc_pkg;

    localparam int         MC_ADDR_W = 25;
    localparam int         MC_DATA_W = 128;
    localparam int         MC_BE_W   = 16;
    localparam logic [4:0] MC_SIZE_1 = 5'd1;

    typedef logic cli_id_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                 we;
        logic [MC_ADDR_W-1:0] addr;
        logic [MC_DATA_W-1:0] wdata;
        logic [MC_BE_W-1:0]   be;
    } mc_req_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mc_arb_tagfifo.sv
// In-order FIFO of client IDs for reads issued but not yet returned.
// Latency: pushed ID visible at head the cycle after push; no backpressure, caller must not push when full.
module mc_arb_tagfifo
    import MCPU_mc_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  cli_id_t       i_id,
    input  logic          i_pop,
    output cli_id_t       o_head,
    output logic [CW-1:0] o_cnt,
    output logic          o_full,
    output logic          o_empty
);

    localparam int            AW      = CW - 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    cli_id_t       r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) r_wp <= r_wp + AW'(1);
            if (i_pop)  r_rp <= r_rp + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Storage needs no reset: entries are only read while count is non-zero.
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wp] <= i_id;
    end

    assign o_head  = r_mem[r_rp];
    assign o_cnt   = r_cnt;
    assign o_full  = (r_cnt == DEPTH_C);
    assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/mc_arb.sv
// Round-robin arbiter of two single-beat clients onto the MC Avalon port, with in-order read return routing.
// Latency: request presented 1 cycle after grant, cliN_ready same cycle as avl_ready, read data 1 cycle after rdata_valid.
// Backpressure: request held until avl_ready; reads stall at RD_OUTSTANDING in flight. MC_ARB_PERF_EN adds perf counters.
module mc_arb
    import MCPU_mc_pkg::*;
#(
    parameter int RD_OUTSTANDING = 8
) (
    input  logic                 clkrst_avl_clk,
    input  logic                 clkrst_avl_rst,
    input  logic                 mc_ready,
    input  logic                 cli0_valid,
    input  logic                 cli0_we,
    input  logic [MC_ADDR_W-1:0] cli0_addr,
    input  logic [MC_DATA_W-1:0] cli0_wdata,
    input  logic [MC_BE_W-1:0]   cli0_be,
    output logic                 cli0_ready,
    output logic                 cli0_rvalid,
    output logic [MC_DATA_W-1:0] cli0_rdata,
    input  logic                 cli1_valid,
    input  logic                 cli1_we,
    input  logic [MC_ADDR_W-1:0] cli1_addr,
    input  logic [MC_DATA_W-1:0] cli1_wdata,
    input  logic [MC_BE_W-1:0]   cli1_be,
    output logic                 cli1_ready,
    output logic                 cli1_rvalid,
    output logic [MC_DATA_W-1:0] cli1_rdata,
    output logic [MC_ADDR_W-1:0] arb2mc_avl_addr_0,
    output logic [MC_DATA_W-1:0] arb2mc_avl_wdata_0,
    output logic [MC_BE_W-1:0]   arb2mc_avl_be_0,
    output logic                 arb2mc_avl_read_req_0,
    output logic                 arb2mc_avl_write_req_0,
    output logic                 arb2mc_avl_burstbegin_0,
    output logic [4:0]           arb2mc_avl_size_0,
    input  logic                 arb2mc_avl_ready_0,
    input  logic                 arb2mc_avl_rdata_valid_0,
    input  logic [MC_DATA_W-1:0] arb2mc_avl_rdata_0,
    output logic                 arb_err
`ifdef MC_ARB_PERF_EN
    ,
    output logic [31:0]          perf_grant0,
    output logic [31:0]          perf_grant1,
    output logic [31:0]          perf_stall
`endif
);

    localparam int            CW     = $clog2(RD_OUTSTANDING) + 1;
    localparam logic [CW-1:0] RD_MAX = CW'(RD_OUTSTANDING);

    arb_state_t     r_state, w_state_nxt;
    mc_req_t        r_req, w_req_sel;
    cli_id_t        r_gnt, r_last, w_gnt_id;
    logic           r_rd_req, r_wr_req, r_bb;
    logic           r_rvalid0, r_rvalid1, r_err;
    logic [MC_DATA_W-1:0] r_rdata0, r_rdata1;
    logic           w_elig0, w_elig1, w_rd_room, w_grant, w_accept, w_push, w_pop;
    cli_id_t        w_tag_head;
    logic [CW-1:0]  w_tag_cnt;
    logic           w_tag_full, w_tag_empty;

    mc_arb_tagfifo #(.DEPTH(RD_OUTSTANDING), .CW(CW)) u_tagfifo (
        .clk     (clkrst_avl_clk),
        .rst     (clkrst_avl_rst),
        .i_push  (w_push),
        .i_id    (w_gnt_id),
        .i_pop   (w_pop),
        .o_head  (w_tag_head),
        .o_cnt   (w_tag_cnt),
        .o_full  (w_tag_full),
        .o_empty (w_tag_empty)
    );

    always_ff @(posedge clkrst_avl_clk or posedge clkrst_avl_rst) begin
        if (clkrst_avl_rst) r_state <= ST_IDLE;
        else                r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_accept    = 1'b0;
        w_rd_room   = (w_tag_cnt < RD_MAX);
        w_elig0     = cli0_valid && (cli0_we || w_rd_room);
        w_elig1     = cli1_valid && (cli1_we || w_rd_room);
        // On contention favour the client that did not win last time.
        w_gnt_id    = (w_elig0 && w_elig1) ? ~r_last : w_elig1;
        w_req_sel.we    = w_gnt_id ? cli1_we    : cli0_we;
        w_req_sel.addr  = w_gnt_id ? cli1_addr  : cli0_addr;
        w_req_sel.wdata = w_gnt_id ? cli1_wdata : cli0_wdata;
        w_req_sel.be    = w_req_sel.we ? (w_gnt_id ? cli1_be : cli0_be) : {MC_BE_W{1'b1}};
        case (r_state)
            ST_IDLE: begin
                if (mc_ready && (w_elig0 || w_elig1)) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (arb2mc_avl_ready_0) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        w_push = w_grant && !w_req_sel.we && !w_tag_full;
        w_pop  = arb2mc_avl_rdata_valid_0 && !w_tag_empty;
    end

    always_ff @(posedge clkrst_avl_clk or posedge clkrst_avl_rst) begin
        if (clkrst_avl_rst) begin
            r_req    <= '0;
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
            r_bb     <= 1'b0;
            r_gnt    <= 1'b0;
            r_last   <= 1'b1;
        end else begin
            r_bb <= 1'b0;
            if (w_grant) begin
                r_req    <= w_req_sel;
                r_rd_req <= !w_req_sel.we;
                r_wr_req <= w_req_sel.we;
                r_bb     <= 1'b1;
                r_gnt    <= w_gnt_id;
                r_last   <= w_gnt_id;
            end else if (w_accept) begin
                r_rd_req <= 1'b0;
                r_wr_req <= 1'b0;
            end
        end
    end

    always_ff @(posedge clkrst_avl_clk or posedge clkrst_avl_rst) begin
        if (clkrst_avl_rst) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rdata0  <= '0;
            r_rdata1  <= '0;
            r_err     <= 1'b0;
        end else begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            if (arb2mc_avl_rdata_valid_0) begin
                if (w_tag_empty) begin
                    r_err <= 1'b1;
                end else if (w_tag_head) begin
                    r_rvalid1 <= 1'b1;
                    r_rdata1  <= arb2mc_avl_rdata_0;
                end else begin
                    r_rvalid0 <= 1'b1;
                    r_rdata0  <= arb2mc_avl_rdata_0;
                end
            end
        end
    end

`ifdef MC_ARB_PERF_EN
    logic [31:0] r_perf_g0, r_perf_g1, r_perf_st;

    always_ff @(posedge clkrst_avl_clk or posedge clkrst_avl_rst) begin
        if (clkrst_avl_rst) begin
            r_perf_g0 <= '0;
            r_perf_g1 <= '0;
            r_perf_st <= '0;
        end else begin
            if (w_accept && !r_gnt) r_perf_g0 <= sat_inc32(r_perf_g0);
            if (w_accept &&  r_gnt) r_perf_g1 <= sat_inc32(r_perf_g1);
            if ((r_state == ST_ISSUE) && !arb2mc_avl_ready_0) r_perf_st <= sat_inc32(r_perf_st);
        end
    end

    assign perf_grant0 = r_perf_g0;
    assign perf_grant1 = r_perf_g1;
    assign perf_stall  = r_perf_st;
`endif

    assign cli0_ready              = w_accept && !r_gnt;
    assign cli1_ready              = w_accept &&  r_gnt;
    assign cli0_rvalid             = r_rvalid0;
    assign cli1_rvalid             = r_rvalid1;
    assign cli0_rdata              = r_rdata0;
    assign cli1_rdata              = r_rdata1;
    assign arb2mc_avl_addr_0       = r_req.addr;
    assign arb2mc_avl_wdata_0      = r_req.wdata;
    assign arb2mc_avl_be_0         = r_req.be;
    assign arb2mc_avl_read_req_0   = r_rd_req;
    assign arb2mc_avl_write_req_0  = r_wr_req;
    assign arb2mc_avl_burstbegin_0 = r_bb;
    assign arb2mc_avl_size_0       = MC_SIZE_1;
    assign arb_err                 = r_err;

endmodule

// File: tb/tb_mc_arb.sv
// Directed bench for mc_arb: grant order, Avalon hold behaviour, read-slot limit, return routing, reset.
module tb_mc_arb;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mc_ready = 1'b0;
    logic         cli0_valid = 1'b0, cli0_we = 1'b0;
    logic [24:0]  cli0_addr = '0;
    logic [127:0] cli0_wdata = '0;
    logic [15:0]  cli0_be = '0;
    logic         cli1_valid = 1'b0, cli1_we = 1'b0;
    logic [24:0]  cli1_addr = '0;
    logic [127:0] cli1_wdata = '0;
    logic [15:0]  cli1_be = '0;
    logic         avl_ready = 1'b0, avl_rdv = 1'b0;
    logic [127:0] avl_rdata = '0;
    logic         cli0_ready, cli0_rvalid, cli1_ready, cli1_rvalid;
    logic [127:0] cli0_rdata, cli1_rdata;
    logic [24:0]  avl_addr;
    logic [127:0] avl_wdata;
    logic [15:0]  avl_be;
    logic         avl_rd, avl_wr, avl_bb, arb_err;
    logic [4:0]   avl_size;
`ifdef MC_ARB_PERF_EN
    logic [31:0]  perf_grant0, perf_grant1, perf_stall;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mc_arb #(.RD_OUTSTANDING(8)) dut (
        .clkrst_avl_clk           (clk),
        .clkrst_avl_rst           (rst),
        .mc_ready                 (mc_ready),
        .cli0_valid               (cli0_valid),
        .cli0_we                  (cli0_we),
        .cli0_addr                (cli0_addr),
        .cli0_wdata               (cli0_wdata),
        .cli0_be                  (cli0_be),
        .cli0_ready               (cli0_ready),
        .cli0_rvalid              (cli0_rvalid),
        .cli0_rdata               (cli0_rdata),
        .cli1_valid               (cli1_valid),
        .cli1_we                  (cli1_we),
        .cli1_addr                (cli1_addr),
        .cli1_wdata               (cli1_wdata),
        .cli1_be                  (cli1_be),
        .cli1_ready               (cli1_ready),
        .cli1_rvalid              (cli1_rvalid),
        .cli1_rdata               (cli1_rdata),
        .arb2mc_avl_addr_0        (avl_addr),
        .arb2mc_avl_wdata_0       (avl_wdata),
        .arb2mc_avl_be_0          (avl_be),
        .arb2mc_avl_read_req_0    (avl_rd),
        .arb2mc_avl_write_req_0   (avl_wr),
        .arb2mc_avl_burstbegin_0  (avl_bb),
        .arb2mc_avl_size_0        (avl_size),
        .arb2mc_avl_ready_0       (avl_ready),
        .arb2mc_avl_rdata_valid_0 (avl_rdv),
        .arb2mc_avl_rdata_0       (avl_rdata),
        .arb_err                  (arb_err)
`ifdef MC_ARB_PERF_EN
        ,
        .perf_grant0              (perf_grant0),
        .perf_grant1              (perf_grant1),
        .perf_stall               (perf_stall)
`endif
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Single read from client id with avl_ready already high; checks issue and acceptance.
    task automatic do_read(input logic id, input logic [24:0] a);
        if (id) begin
            cli1_valid = 1'b1; cli1_we = 1'b0; cli1_addr = a;
        end else begin
            cli0_valid = 1'b1; cli0_we = 1'b0; cli0_addr = a;
        end
        step();
        check("rd_req", avl_rd, 1'b1);
        check("rd_addr", avl_addr, a);
        check("rd_be", avl_be, 16'hFFFF);
        check("rd_ready", id ? cli1_ready : cli0_ready, 1'b1);
        check("rd_ready_other", id ? cli0_ready : cli1_ready, 1'b0);
        cli0_valid = 1'b0;
        cli1_valid = 1'b0;
        step();
    endtask

    logic [127:0] ret_dat [4];
    logic         ret_id  [4];
    logic [127:0] last0, last1;
    logic         exp_id;

    initial begin
        // Reset state
        step();
        check("rst_rd", avl_rd, 1'b0);
        check("rst_wr", avl_wr, 1'b0);
        check("rst_bb", avl_bb, 1'b0);
        check("rst_size", avl_size, 5'd1);
        check("rst_be", avl_be, 16'h0);
        check("rst_err", arb_err, 1'b0);
        check("rst_rv0", cli0_rvalid, 1'b0);
        rst = 1'b0;
        mc_ready = 1'b1;
        step();

        // 1: single read from client 0 and its return
        avl_ready = 1'b1;
        cli0_valid = 1'b1; cli0_we = 1'b0; cli0_addr = 25'h10;
        step();
        check("t1_rd", avl_rd, 1'b1);
        check("t1_bb", avl_bb, 1'b1);
        check("t1_addr", avl_addr, 25'h10);
        check("t1_rdy0", cli0_ready, 1'b1);
        check("t1_rdy1", cli1_ready, 1'b0);
        cli0_valid = 1'b0;
        step();
        check("t1_rd_drop", avl_rd, 1'b0);
        check("t1_rdy0_drop", cli0_ready, 1'b0);
        avl_rdv = 1'b1; avl_rdata = {16{8'hAA}};
        step();
        avl_rdv = 1'b0;
        check("t1_rv0", cli0_rvalid, 1'b1);
        check("t1_rd0", cli0_rdata, {16{8'hAA}});
        check("t1_rv1", cli1_rvalid, 1'b0);
        step();
        check("t1_rv0_pulse", cli0_rvalid, 1'b0);

        // 2: both clients writing continuously, grants alternate 0,1,0,1
        do_reset();
        cli0_valid = 1'b1; cli0_we = 1'b1; cli0_addr = 25'h100; cli0_wdata = {8{16'h1111}}; cli0_be = 16'h00FF;
        cli1_valid = 1'b1; cli1_we = 1'b1; cli1_addr = 25'h200; cli1_wdata = {8{16'h2222}}; cli1_be = 16'hFF00;
        for (int i = 0; i < 4; i++) begin
            exp_id = i[0];
            step();
            check("t2_wr", avl_wr, 1'b1);
            check("t2_rd", avl_rd, 1'b0);
            check("t2_bb", avl_bb, 1'b1);
            check("t2_wdata", avl_wdata, exp_id ? {8{16'h2222}} : {8{16'h1111}});
            check("t2_be", avl_be, exp_id ? 16'hFF00 : 16'h00FF);
            check("t2_rdy0", cli0_ready, !exp_id);
            check("t2_rdy1", cli1_ready, exp_id);
            step();
            check("t2_gap", avl_wr, 1'b0);
        end
        cli0_valid = 1'b0; cli1_valid = 1'b0;
        step();

        // 3: MC stalls 5 cycles; mc_ready drop does not abort
        avl_ready = 1'b0;
        cli1_valid = 1'b1; cli1_we = 1'b1; cli1_addr = 25'h1ABCDE; cli1_wdata = {4{32'h3333_CAFE}}; cli1_be = 16'h0F0F;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 1) mc_ready = 1'b0;
            check("t3_wr", avl_wr, 1'b1);
            check("t3_bb", avl_bb, (i == 0));
            check("t3_addr", avl_addr, 25'h1ABCDE);
            check("t3_wdata", avl_wdata, {4{32'h3333_CAFE}});
            check("t3_be", avl_be, 16'h0F0F);
            check("t3_rdy1", cli1_ready, 1'b0);
        end
        avl_ready = 1'b1;
        #1;
        check("t3_accept", cli1_ready, 1'b1);
        cli1_valid = 1'b0;
        step();
        check("t3_wr_drop", avl_wr, 1'b0);
        mc_ready = 1'b1;

        // 4: eight reads fill the tag FIFO; ninth blocked, write still passes
        do_reset();
        for (int i = 0; i < 8; i++) do_read(1'b1, 25'(i));
        cli1_valid = 1'b1; cli1_we = 1'b0; cli1_addr = 25'h8;
        step();
        check("t4_blk_rd", avl_rd, 1'b0);
        check("t4_blk_rdy", cli1_ready, 1'b0);
        cli0_valid = 1'b1; cli0_we = 1'b1; cli0_addr = 25'h55; cli0_wdata = {8{16'h5555}}; cli0_be = 16'hFFFF;
        step();
        check("t4_wr", avl_wr, 1'b1);
        check("t4_wr_rdy0", cli0_ready, 1'b1);
        check("t4_wr_rdy1", cli1_ready, 1'b0);
        cli0_valid = 1'b0;
        step();
        step();
        check("t4_still_blk", avl_rd, 1'b0);
        avl_rdv = 1'b1; avl_rdata = {8{16'h9999}};
        step();
        avl_rdv = 1'b0;
        check("t4_ret_rv1", cli1_rvalid, 1'b1);
        check("t4_ret_rd1", cli1_rdata, {8{16'h9999}});
        step();
        check("t4_rd9", avl_rd, 1'b1);
        check("t4_rd9_addr", avl_addr, 25'h8);
        check("t4_rd9_rdy", cli1_ready, 1'b1);
        cli1_valid = 1'b0;
        step();

        // 5: reads 0,1,1,0 return in order to the right client; then spurious beat
        do_reset();
        ret_id[0] = 1'b0; ret_id[1] = 1'b1; ret_id[2] = 1'b1; ret_id[3] = 1'b0;
        ret_dat[0] = {4{32'hD000_0000}}; ret_dat[1] = {4{32'hD111_1111}};
        ret_dat[2] = {4{32'hD222_2222}}; ret_dat[3] = {4{32'hD333_3333}};
        for (int i = 0; i < 4; i++) do_read(ret_id[i], 25'(32 + i));
        last0 = '0;
        last1 = '0;
        for (int i = 0; i < 4; i++) begin
            avl_rdv = 1'b1; avl_rdata = ret_dat[i];
            step();
            avl_rdv = 1'b0;
            if (ret_id[i]) last1 = ret_dat[i];
            else           last0 = ret_dat[i];
            check("t5_rv0", cli0_rvalid, !ret_id[i]);
            check("t5_rv1", cli1_rvalid, ret_id[i]);
            check("t5_rd0", cli0_rdata, last0);
            check("t5_rd1", cli1_rdata, last1);
        end
        check("t5_err_clean", arb_err, 1'b0);
        avl_rdv = 1'b1; avl_rdata = {16{8'hEE}};
        step();
        avl_rdv = 1'b0;
        check("t5_err", arb_err, 1'b1);
        check("t5_drop_rv0", cli0_rvalid, 1'b0);
        check("t5_drop_rv1", cli1_rvalid, 1'b0);
        check("t5_drop_rd0", cli0_rdata, last0);
        step();
        step();
        check("t5_err_sticky", arb_err, 1'b1);

        // 6: async reset during a held request with 3 reads outstanding
        for (int i = 0; i < 3; i++) do_read(1'b0, 25'(64 + i));
        avl_ready = 1'b0;
        cli0_valid = 1'b1; cli0_we = 1'b0; cli0_addr = 25'h77;
        step();
        check("t6_held", avl_rd, 1'b1);
        rst = 1'b1;
        avl_ready = 1'b1;
        #1;
        check("t6_rst_rd", avl_rd, 1'b0);
        check("t6_rst_bb", avl_bb, 1'b0);
        check("t6_rst_addr", avl_addr, 25'h0);
        check("t6_rst_be", avl_be, 16'h0);
        check("t6_rst_err", arb_err, 1'b0);
        check("t6_rst_rdy", cli0_ready, 1'b0);
        cli0_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        check("t6_idle", avl_rd, 1'b0);
        avl_rdv = 1'b1; avl_rdata = {16{8'h33}};
        step();
        avl_rdv = 1'b0;
        check("t6_fifo_empty", arb_err, 1'b1);
        check("t6_no_rv0", cli0_rvalid, 1'b0);
        do_read(1'b1, 25'h42);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
